gpio_bus_arbiter: RTL
=====================

// Module: gpio_bus_arbiter
// PURPOSE
//  Shares the single-master register port of the GPIO peripheral (OGPIO/TRIS/IGPIO at
//  offsets 0/1/2) between two requesters, e.g. the CPU and a pattern/DMA engine.
//  Round-robin arbitration, one register access per grant, registered read-data return.
//  Sits between the requesters and the GPIO port on one clock domain.
// PARAMETERS
//  ADDR_W      8  width of register address (passed through unchanged)
//  DATA_W      8  width of register data
//  RD_LATENCY  1  cycles from m_rd_en asserted to m_dout valid (legal range 1..7)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  req          in   2       per-requester access request, level, held until gnt
//  req_we       in   2       1=write, 0=read, per requester
//  req_addr     in   2*ADDR_W  packed {r1,r0} register address
//  req_wdata    in   2*DATA_W  packed {r1,r0} write data
//  gnt          out  2       one-cycle pulse: access issued to GPIO this cycle
//  rvalid       out  2       one-cycle pulse: rdata valid for that requester
//  rdata        out  DATA_W  read data, shared, qualified by rvalid
//  m_addr       out  ADDR_W  to GPIO addr
//  m_din        out  DATA_W  to GPIO din
//  m_wr_en      out  1       to GPIO wr_en
//  m_rd_en      out  1       to GPIO rd_en
//  m_dout       in   DATA_W  from GPIO dout
// BEHAVIOUR
//  Reset: gnt=0, rvalid=0, rdata=0, m_addr=0, m_din=0, m_wr_en=0, m_rd_en=0, state=IDLE,
//   priority pointer=0 (requester 0 favoured first). All outputs registered.
//  FSM IDLE -> ISSUE -> (write) IDLE | (read) RDWAIT -> IDLE.
//  IDLE: if req!=0, pick winner w (sole requester, or pointer side if both); latch
//   req_we/addr/wdata of w into m_* regs; go ISSUE. Else stay, m_* strobes 0.
//  ISSUE (1 cycle): m_wr_en=we or m_rd_en=~we asserted; gnt[w]=1; pointer <= ~w.
//   Write -> IDLE. Read -> RDWAIT with latency counter loaded to RD_LATENCY.
//  RDWAIT: counter decrements; on the cycle m_dout is valid (RD_LATENCY cycles after
//   ISSUE) capture into rdata, pulse rvalid[w] next cycle, return IDLE.
//  Requester rule: req/we/addr/wdata stable from req rise until gnt; req dropped in
//   the cycle after gnt, else treated as a new request. rdata held until next read.
//  Throughput: write 2 cycles/access; read 2+RD_LATENCY cycles; never two accesses
//   outstanding; m_wr_en and m_rd_en never high together.
//  Fairness: with both req held, grants alternate 0,1,0,1...; single requester may
//   take every slot. Pointer only moves on a grant.
//  Request withdrawn before sampling in IDLE: ignored, no grant. Request changes
//   after latch: ignored until next IDLE.
//  Reset mid-operation (any state): immediate return to reset values; pending read
//   discarded, no rvalid emitted after release.
//  Addresses are not decoded: unmapped offsets pass through (GPIO returns 0 on read).
// STRUCTURE
//  Shared include gpio_arb_defs.vh: state encodings IDLE/ISSUE/RDWAIT, requester
//   count constant (2), GPIO register offsets (OGPIO=0, TRIS=1, IGPIO=2).
//  One sub-module: rr_arb2 (req[1:0], pointer -> one-hot winner, combinational).
//  Top holds FSM, latency counter, latched request, pointer, read-return path.
// TESTING
//  T1 write: req[0], we=1, addr=0x00, wdata=0xA5 -> next cycle IDLE latch, following
//   cycle m_wr_en=1, m_addr=0, m_din=0xA5, gnt=2'b01; GPIO OGPIO reads back 0xA5.
//  T2 read: after TRIS=0x0F, req[1] read addr=0x01 -> gnt=2'b10, m_rd_en one cycle,
//   rvalid=2'b10 with rdata=0x0F exactly RD_LATENCY+1 cycles after gnt.
//  T3 contention: both req held, writes 0x11 (r0) / 0x22 (r1) to addr 0 -> gnt order
//   01,10,01,10; OGPIO alternates 0x11/0x22; strobes never overlap.
//  T4 reset mid-read: assert reset_n=0 during RDWAIT -> all outputs 0 asynchronously,
//   no rvalid after release; next req[0] granted first (pointer=0).
//  T5 RD_LATENCY=3 build: read IGPIO with port driven 0x3C -> rvalid 4 cycles after
//   gnt, rdata=0x3C; no new grant issued while in RDWAIT though req[0] held.
//  T6 withdrawn request: req[1] pulsed one cycle while FSM in ISSUE for r0 -> no gnt[1].

Source files
------------

// File: rtl/gpio_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gpio_bus_arbiter_pkg
// Description : Shared definitions for the GPIO register-port arbiter.
//               - FSM state encoding (IDLE / ISSUE / RDWAIT)
//               - requester count and latency-counter width
//               - GPIO register offsets (OGPIO / TRIS / IGPIO)
//               - helper turning a requester index into a one-hot vector
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_t;

    localparam int C_NUM_REQ = 2;

    // Wide enough for the largest legal read latency (7).
    localparam int C_CNT_W = 3;

    // GPIO register map. The arbiter does not decode addresses; these are
    // shared so requesters and models agree on the map.
    localparam logic [7:0] C_OFS_OGPIO = 8'd0;
    localparam logic [7:0] C_OFS_TRIS  = 8'd1;
    localparam logic [7:0] C_OFS_IGPIO = 8'd2;

    function automatic logic [C_NUM_REQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage : gpio_bus_arbiter_pkg
`default_nettype wire

// File: rtl/gpio_bus_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin pick, purely combinational.
//               A sole requester always wins; on contention the side named
//               by the priority pointer wins.
// Ports       : i_req   [1:0] - request vector
//               i_ptr         - favoured requester when both request
//               o_grant [1:0] - one-hot winner (zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import gpio_bus_arbiter_pkg::*;
(
    input  logic [C_NUM_REQ-1:0] i_req,
    input  logic                 i_ptr,
    output logic [C_NUM_REQ-1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        if (i_req == 2'b11) begin
            o_grant = req_onehot(i_ptr);
        end else begin
            o_grant = i_req;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/gpio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpio_bus_arbiter
// Description : Shares the single-master GPIO register port between two
//               requesters. Round-robin arbitration, one register access per
//               grant, registered read-data return. All outputs registered.
// Ports       : clk, reset_n            - clock, async active-low reset
//               req/req_we [1:0]        - request level and write select
//               req_addr/req_wdata      - packed {r1,r0} address / write data
//               gnt [1:0]               - pulse: access issued this cycle
//               rvalid [1:0]            - pulse: rdata valid for requester
//               rdata                   - shared read data, held to next read
//               m_addr/m_din/m_wr_en/m_rd_en/m_dout - GPIO register port
// Parameters  : ADDR_W, DATA_W, RD_LATENCY (1..7 cycles rd_en -> dout)
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_bus_arbiter
    import gpio_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
)
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [C_NUM_REQ-1:0]          req,
    input  logic [C_NUM_REQ-1:0]          req_we,
    input  logic [C_NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [C_NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [C_NUM_REQ-1:0]          gnt,
    output logic [C_NUM_REQ-1:0]          rvalid,
    output logic [DATA_W-1:0]             rdata,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [DATA_W-1:0]             m_din,
    output logic                          m_wr_en,
    output logic                          m_rd_en,
    input  logic [DATA_W-1:0]             m_dout
);

    localparam logic [C_CNT_W-1:0] C_RD_LAT = C_CNT_W'(RD_LATENCY);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE = C_CNT_W'(1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    arb_state_t                 r_state;
    arb_state_t                 w_next_state;

    logic                       r_ptr;
    logic                       r_win;
    logic                       r_we;
    logic [C_CNT_W-1:0]         r_cnt;
    logic [C_NUM_REQ-1:0]       r_gnt;
    logic [C_NUM_REQ-1:0]       r_rvalid;
    logic [DATA_W-1:0]          r_rdata;
    logic [ADDR_W-1:0]          r_m_addr;
    logic [DATA_W-1:0]          r_m_din;
    logic                       r_m_wr_en;
    logic                       r_m_rd_en;

    // Next-state values computed in the combinational process
    logic                       w_ptr_nxt;
    logic                       w_win_nxt;
    logic                       w_we_nxt;
    logic [C_CNT_W-1:0]         w_cnt_nxt;
    logic [C_NUM_REQ-1:0]       w_gnt_nxt;
    logic [C_NUM_REQ-1:0]       w_rvalid_nxt;
    logic [DATA_W-1:0]          w_rdata_nxt;
    logic [ADDR_W-1:0]          w_m_addr_nxt;
    logic [DATA_W-1:0]          w_m_din_nxt;
    logic                       w_m_wr_en_nxt;
    logic                       w_m_rd_en_nxt;

    // ------------------------------------------------------------------
    // Arbitration and winner's request fields
    // ------------------------------------------------------------------
    logic [C_NUM_REQ-1:0]       w_grant;
    logic                       w_win;
    logic                       w_sel_we;
    logic [ADDR_W-1:0]          w_sel_addr;
    logic [DATA_W-1:0]          w_sel_wdata;

    rr_arb2 u_rr_arb2 (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    // Only meaningful when w_grant is non-zero (IDLE with a request).
    assign w_win       = w_grant[1];
    assign w_sel_we    = w_win ? req_we[1] : req_we[0];
    assign w_sel_addr  = w_win ? req_addr[2*ADDR_W-1:ADDR_W]
                               : req_addr[ADDR_W-1:0];
    assign w_sel_wdata = w_win ? req_wdata[2*DATA_W-1:DATA_W]
                               : req_wdata[DATA_W-1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and next register values
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_ptr_nxt     = r_ptr;
        w_win_nxt     = r_win;
        w_we_nxt      = r_we;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = '0;
        w_rvalid_nxt  = '0;
        w_rdata_nxt   = r_rdata;
        w_m_addr_nxt  = r_m_addr;
        w_m_din_nxt   = r_m_din;
        w_m_wr_en_nxt = 1'b0;
        w_m_rd_en_nxt = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // Latch the winner now so strobes, address and gnt all
                // appear together from registers in the ISSUE cycle.
                if (req != '0) begin
                    w_next_state  = ST_ISSUE;
                    w_win_nxt     = w_win;
                    w_we_nxt      = w_sel_we;
                    w_m_addr_nxt  = w_sel_addr;
                    w_m_din_nxt   = w_sel_wdata;
                    w_gnt_nxt     = w_grant;
                    w_m_wr_en_nxt = w_sel_we;
                    w_m_rd_en_nxt = ~w_sel_we;
                end
            end

            ST_ISSUE: begin
                w_ptr_nxt = ~r_win;
                w_cnt_nxt = C_RD_LAT;
                w_next_state = r_we ? ST_IDLE : ST_RDWAIT;
            end

            ST_RDWAIT: begin
                w_cnt_nxt = r_cnt - C_CNT_ONE;
                // Counter reaches one in the cycle m_dout becomes valid.
                if (r_cnt <= C_CNT_ONE) begin
                    w_rdata_nxt  = m_dout;
                    w_rvalid_nxt = req_onehot(r_win);
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr     <= 1'b0;
            r_win     <= 1'b0;
            r_we      <= 1'b0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_rvalid  <= '0;
            r_rdata   <= '0;
            r_m_addr  <= '0;
            r_m_din   <= '0;
            r_m_wr_en <= 1'b0;
            r_m_rd_en <= 1'b0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_win     <= w_win_nxt;
            r_we      <= w_we_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_din   <= w_m_din_nxt;
            r_m_wr_en <= w_m_wr_en_nxt;
            r_m_rd_en <= w_m_rd_en_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign m_addr  = r_m_addr;
    assign m_din   = r_m_din;
    assign m_wr_en = r_m_wr_en;
    assign m_rd_en = r_m_rd_en;

endmodule : gpio_bus_arbiter
`default_nettype wire
